mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Data-memory access stage. Sits between the EX/MEM register and the MEM/WB register, and produces the MemRdata value that MEM/WB carries to writeback. It holds a word-addressed data memory with a configurable multi-cycle access latency. While an access is in flight it stalls the pipeline through a request/stall/done handshake. It flags misaligned, out-of-range and conflicting accesses without touching memory.

Parameters:
- DEPTH, 256: number of 32-bit words in the data memory (power of 2).
- LATENCY, 3: cycles for which stall_o is high per access (≥1).

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_i  input  1  reset, synchronous, active-low.
- MemRead_i  input  1  load request from EX/MEM.
- MemWrite_i  input  1  store request from EX/MEM.
- addr_i  input  32  byte address (ALU result).
- wdata_i  input  32  store data.
- flush_i  input  1  abort the in-flight access.
- MemRdata_o  output  32  load data to MEM/WB.
- stall_o  output  1  freeze upstream stages and the EX/MEM register.
- done_o  output  1  one-cycle pulse: access completed this cycle.
- err_o  output  1  one-cycle pulse: request rejected.

Behaviour:
- Reset (rst_i==0 at a rising edge): state=IDLE, counter=0, MemRdata_o=0, done_o=0, err_o=0, stall_o=0. Memory array is not cleared. Reset has priority over every other input. A reset during BUSY aborts the access and does not commit a pending write.
- Request: req = MemRead_i | MemWrite_i, sampled only in IDLE.
- Word index: addr_i[31:2]. An access is valid only when all of the following hold: addr_i[1:0]==0, index < DEPTH, and not (MemRead_i & MemWrite_i).
- States: IDLE, BUSY, DONE.
- IDLE, valid req at cycle T:
  - Latch op, word index and wdata.
  - If LATENCY==1, go to DONE. Otherwise go to BUSY with counter=LATENCY-2.
- IDLE, invalid req:
  - err_o=1 in the next cycle only.
  - No memory access, no stall, state stays IDLE.
- BUSY:
  - If counter==0, go to DONE. Otherwise decrement the counter.
  - flush_i=1 in BUSY: go to IDLE, no write commit, done_o stays 0.
- Transition into DONE (edge ending cycle T+LATENCY-1):
  - Write: mem[index] <= latched wdata.
  - Read: MemRdata_o <= mem[index].
- DONE (cycle T+LATENCY):
  - done_o=1, stall_o=0.
  - Unconditionally go to IDLE on the next edge. A request still asserted during DONE is the completed instruction and is never re-accepted.
  - flush_i is ignored in DONE.
- stall_o is combinational: 1 in IDLE with a valid req, and 1 in BUSY; 0 otherwise. It is therefore high for exactly LATENCY consecutive cycles per valid access, starting in the request cycle.
- MemRdata_o changes only when a read completes. Writes, errors and flushes leave it unchanged.
- Back-to-back: a new request can be accepted in the IDLE cycle that immediately follows DONE. Minimum issue interval is LATENCY+1 cycles.
- flush_i in IDLE: the request in that same cycle is still evaluated normally.

Test Plan:
1. LATENCY=3: reset, write 0xDEADBEEF to addr 0x10, then read addr 0x10.
   - stall_o high 3 cycles per access; done_o pulses on the 4th cycle.
   - MemRdata_o=0xDEADBEEF in the read's DONE cycle; it stays 0 after the write.
2. Read with addr 0x13 (misaligned), then addr 0x400 with DEPTH=256 (out of range).
   - err_o pulses one cycle each; stall_o never asserts; MemRdata_o unchanged.
3. MemRead_i=MemWrite_i=1, addr 0x8 → err_o pulse, no stall; a subsequent read of 0x8 returns the prior contents.
4. Write 0x12345678 to 0x20, assert flush_i in the second BUSY cycle.
   - stall_o drops the next cycle; done_o never pulses.
   - A later read of 0x20 returns the old value.
5. Write 0xCAFEF00D to 0x24 with rst_i=0 mid-BUSY.
   - All outputs 0 the next cycle.
   - After re-init, a read of 0x24 returns the value from before the aborted write.
6. LATENCY=1: hold MemRead_i high across consecutive read requests to different addresses.
   - stall_o high 1 cycle and done_o each alternate cycle.
   - Each instruction is accepted exactly once, with no re-accept in DONE.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage
// ----------------
// Data-memory access stage between the EX/MEM and MEM/WB registers. It holds a
// word-addressed data memory and takes a fixed LATENCY cycles per access.
// During an access the upstream pipeline is frozen through stall_o. A one-cycle
// done_o pulse marks completion. Misaligned, out-of-range and read+write
// requests are rejected with a one-cycle err_o pulse and do not touch memory.
//
// Ports
//   clk_i       rising-edge clock
//   rst_i       synchronous active-low reset (memory contents are kept)
//   MemRead_i   load request from EX/MEM
//   MemWrite_i  store request from EX/MEM
//   addr_i      byte address; word index is addr_i[31:2]
//   wdata_i     store data
//   flush_i     abort an access that is in BUSY
//   MemRdata_o  load data to MEM/WB; changes only when a read completes
//   stall_o     freeze upstream stages (combinational)
//   done_o      one-cycle pulse in the cycle the access completes
//   err_o       one-cycle pulse in the cycle after a rejected request
module mem_access_stage #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  output logic [31:0] MemRdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  // BUSY lasts LATENCY-1 cycles, so the counter starts at LATENCY-2 and the
  // final BUSY cycle is the one that sees zero.
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            op_write_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem [DEPTH];

  logic            req;
  logic            in_range;
  logic            valid;
  logic            accept;
  logic [AW-1:0]   idx_in;
  logic            commit;
  logic            commit_write;
  logic [AW-1:0]   commit_idx;
  logic [31:0]     commit_wdata;

  assign req      = MemRead_i | MemWrite_i;
  assign idx_in   = addr_i[AW+1:2];
  // Index < DEPTH is the same as every address bit above the index being zero.
  assign in_range = (addr_i[31:AW+2] == '0);
  assign valid    = req && (addr_i[1:0] == 2'b00) && in_range &&
                    !(MemRead_i && MemWrite_i);
  assign accept   = (state == IDLE) && valid;
  assign stall_o  = accept || (state == BUSY);

  // The memory is touched on the edge that enters DONE. With LATENCY==1 that
  // is the accepting edge itself, so the operands come straight from the
  // inputs instead of the latched copies.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    commit       = 1'b0;
    commit_write = op_write_q;
    commit_idx   = idx_q;
    commit_wdata = wdata_q;
    if (state == IDLE) begin
      commit       = accept && (LATENCY == 1);
      commit_write = MemWrite_i;
      commit_idx   = idx_in;
      commit_wdata = wdata_i;
    end else if (state == BUSY) begin
      commit = !flush_i && (cnt == '0);
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      MemRdata_o <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end else if (req) begin
            err_o <= 1'b1;
          end
        end
        BUSY: begin
          if (flush_i) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        // A request still present in DONE belongs to the access just
        // completed, so DONE always returns to IDLE without sampling it.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit && !commit_write) begin
        MemRdata_o <= mem[commit_idx];
      end
    end
  end

  // Operands of the accepted request, held for the BUSY cycles.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_write_q <= MemWrite_i;
      idx_q      <= idx_in;
      wdata_q    <= wdata_i;
    end
  end

  // NOTE: the memory array has no reset; its contents survive rst_i and only a
  // completed store changes them. A reset edge blocks the commit.
  always_ff @(posedge clk_i) begin
    if (rst_i && commit && commit_write) begin
      mem[commit_idx] <= commit_wdata;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage. Two instances are used: one with LATENCY=3 and
// one with LATENCY=1. Each access is described by its request and optional
// flush/reset cycle. The expected per-cycle outputs come from the access
// timeline: stall for LATENCY cycles, then done, then an idle return. A small
// word array stands in for the data memory. A negedge process compares both
// instances every cycle. Literal checks pin the key values.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        rd, wr, flush;
  logic [31:0] addr, wdata;

  logic        rd3, wr3, fl3, rd1, wr1, fl1;
  assign rd3 = rd & ~sel;
  assign wr3 = wr & ~sel;
  assign fl3 = flush & ~sel;
  assign rd1 = rd & sel;
  assign wr1 = wr & sel;
  assign fl1 = flush & sel;

  logic [31:0] rdata3, rdata1;
  logic        stall3, done3, err3, stall1, done1, err1;

  mem_access_stage #(.DEPTH(256), .LATENCY(3)) dut3 (
    .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd3), .MemWrite_i(wr3),
    .addr_i(addr), .wdata_i(wdata), .flush_i(fl3),
    .MemRdata_o(rdata3), .stall_o(stall3), .done_o(done3), .err_o(err3)
  );

  mem_access_stage #(.DEPTH(256), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd1), .MemWrite_i(wr1),
    .addr_i(addr), .wdata_i(wdata), .flush_i(fl1),
    .MemRdata_o(rdata1), .stall_o(stall1), .done_o(done1), .err_o(err1)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        ex [2];
  logic [31:0] mmem [2][256];
  bit          chk_en = 1'b0;
  int          stall_cnt [2];
  int          done_cnt  [2];
  int          err_cnt   [2];

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall3", stall3, ex[0].stall);
      check("done3",  done3,  ex[0].done);
      check("err3",   err3,   ex[0].err);
      check("rdata3", rdata3, ex[0].rdata);
      check("stall1", stall1, ex[1].stall);
      check("done1",  done1,  ex[1].done);
      check("err1",   err1,   ex[1].err);
      check("rdata1", rdata1, ex[1].rdata);
      if (stall3) stall_cnt[0]++;
      if (done3)  done_cnt[0]++;
      if (err3)   err_cnt[0]++;
      if (stall1) stall_cnt[1]++;
      if (done1)  done_cnt[1]++;
      if (err1)   err_cnt[1]++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    for (int i = 0; i < 2; i++) begin
      ex[i].stall = 1'b0;
      ex[i].done  = 1'b0;
      ex[i].err   = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    rd    = 1'b0;
    wr    = 1'b0;
    flush = 1'b0;
    repeat (n) begin
      quiet();
      step();
    end
  endtask

  // One access on instance s (0: LATENCY=3, 1: LATENCY=1). The request is held
  // through the DONE cycle, as the EX/MEM register would hold it. flush_at and
  // rst_at name the cycle (0 = request cycle) in which flush_i or reset is
  // applied, or -1 for none.
  task automatic access(input int s, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d,
                        input int flush_at, input int rst_at);
    int lat = (s == 1) ? 1 : 3;
    bit ok;
    int idx;
    ok  = (a[1:0] == 2'b00) && ((a >> 2) < 256) && !(r && w);
    idx = int'(a[9:2]);
    sel   = s[0];
    rd    = r;
    wr    = w;
    addr  = a;
    wdata = d;
    flush = 1'b0;
    if (!ok) begin
      quiet();
      step();
      rd = 1'b0;
      wr = 1'b0;
      quiet();
      ex[s].err = 1'b1;
      step();
      return;
    end
    for (int k = 0; k <= lat; k++) begin
      quiet();
      flush = (k == flush_at);
      rst_n = !(k == rst_at);
      if (k < lat) begin
        ex[s].stall = 1'b1;
      end else begin
        ex[s].done = 1'b1;
        if (r) ex[s].rdata = mmem[s][idx];
        else   mmem[s][idx] = d;
      end
      step();
      if (k == flush_at || k == rst_at) begin
        rd    = 1'b0;
        wr    = 1'b0;
        flush = 1'b0;
        rst_n = 1'b1;
        quiet();
        if (k == rst_at) begin
          ex[0].rdata = '0;
          ex[1].rdata = '0;
        end
        step();
        return;
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    sel   = 1'b0;
    rd    = 1'b0;
    wr    = 1'b0;
    flush = 1'b0;
    addr  = '0;
    wdata = '0;
    quiet();
    ex[0].rdata = '0;
    ex[1].rdata = '0;
    for (int i = 0; i < 2; i++) begin
      stall_cnt[i] = 0;
      done_cnt[i]  = 0;
      err_cnt[i]   = 0;
    end
    step();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    idle(2);
    for (int i = 0; i < 2; i++) begin
      stall_cnt[i] = 0;
      done_cnt[i]  = 0;
      err_cnt[i]   = 0;
    end

    // 1: write then read back, LATENCY=3.
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, -1, -1);
    check("t1_write_stall_cycles", stall_cnt[0], 3);
    check("t1_write_done_pulses", done_cnt[0], 1);
    check("t1_rdata_after_write", rdata3, 32'h0);
    idle(1);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, -1, -1);
    check("t1_read_data", rdata3, 32'hDEADBEEF);
    check("t1_total_stall_cycles", stall_cnt[0], 6);
    idle(1);

    // Last valid word, then read it back.
    access(0, 1'b0, 1'b1, 32'h3FC, 32'h0000_03FC, -1, -1);
    access(0, 1'b1, 1'b0, 32'h3FC, 32'h0, -1, -1);
    check("top_word_read", rdata3, 32'h0000_03FC);
    idle(1);

    // 2: misaligned and out-of-range reads.
    stall_cnt[0] = 0;
    err_cnt[0]   = 0;
    access(0, 1'b1, 1'b0, 32'h13, 32'h0, -1, -1);
    access(0, 1'b1, 1'b0, 32'h400, 32'h0, -1, -1);
    idle(1);
    check("t2_err_pulses", err_cnt[0], 2);
    check("t2_no_stall", stall_cnt[0], 0);
    check("t2_rdata_kept", rdata3, 32'h0000_03FC);

    // 3: read and write together is rejected; memory is untouched.
    access(0, 1'b0, 1'b1, 32'h8, 32'hA5A5_0008, -1, -1);
    access(0, 1'b1, 1'b1, 32'h8, 32'hFFFF_FFFF, -1, -1);
    idle(1);
    access(0, 1'b1, 1'b0, 32'h8, 32'h0, -1, -1);
    check("t3_prior_contents", rdata3, 32'hA5A5_0008);
    idle(1);

    // 4: flush in the second BUSY cycle aborts the store.
    access(0, 1'b0, 1'b1, 32'h20, 32'h0BAD_C0DE, -1, -1);
    done_cnt[0] = 0;
    access(0, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 2, -1);
    check("t4_no_done_after_flush", done_cnt[0], 0);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, -1, -1);
    check("t4_old_value", rdata3, 32'h0BAD_C0DE);
    idle(1);

    // 5: reset in the first BUSY cycle aborts the store.
    access(0, 1'b0, 1'b1, 32'h24, 32'h1111_2222, -1, -1);
    access(0, 1'b0, 1'b1, 32'h24, 32'hCAFE_F00D, -1, 1);
    check("t5_rdata_after_reset", rdata3, 32'h0);
    idle(1);
    access(0, 1'b1, 1'b0, 32'h24, 32'h0, -1, -1);
    check("t5_value_survives_reset", rdata3, 32'h1111_2222);
    idle(1);

    // 6: LATENCY=1 back-to-back with the request held through DONE.
    stall_cnt[1] = 0;
    done_cnt[1]  = 0;
    access(1, 1'b0, 1'b1, 32'h40, 32'h0000_0001, -1, -1);
    access(1, 1'b0, 1'b1, 32'h44, 32'h0000_0002, -1, -1);
    idle(1);
    access(1, 1'b1, 1'b0, 32'h40, 32'h0, -1, -1);
    check("t6_first_read", rdata1, 32'h0000_0001);
    access(1, 1'b1, 1'b0, 32'h44, 32'h0, -1, -1);
    check("t6_second_read", rdata1, 32'h0000_0002);
    idle(2);
    check("t6_accepts", stall_cnt[1], 4);
    check("t6_done_pulses", done_cnt[1], 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
